alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Instruction-side counterpart of the 16-bit ALU: owns the 8x16 register file and decodes 16-bit instructions.
- Drives ALU operands and operation select, captures the ALU result, and writes it back to the register file.
- Sits between the instruction source (valid/ready) and the combinational ALU.
- Sequences one instruction at a time through a 4-state FSM.

Parameters:
- ZERO_R0, 1, when 1 register r0 always reads 0x0000 and writes to it are dropped.
- RF_RESET_VAL, 16'h0000, value loaded into every register on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  16  instruction word.
- instr_valid  in  1  instr is valid this cycle.
- instr_ready  out  1  block can accept an instruction.
- aluA  out  16  ALU operand A, registered.
- aluB  out  16  ALU operand B, registered.
- aluOp  out  1  ALU operation: 0 = A+B, 1 = {B[7:0],8'd0}.
- aluResult  in  16  combinational ALU result.
- done  out  1  one-cycle pulse on writeback.
- done_rd  out  3  destination register for the current done pulse.
- illegal  out  1  one-cycle pulse when an undefined opcode retires.
- dbg_addr  in  3  register-file debug read address.
- dbg_data  out  16  combinational read of the register at dbg_addr (r0 reads 0 when ZERO_R0=1).

Behaviour:
- Instruction encoding, opcode = instr[15:12]:
  - 4'h0 ADD: rd=[11:9], ra=[8:6], rb=[5:3]; rd <= ra + rb.
  - 4'h1 LHI: rd=[11:9], imm8=[7:0]; rd <= {imm8, 8'h00}.
  - 4'h2 ADDI: rd=[11:9], ra=[8:6], imm6=[5:0] sign-extended to 16 bits; rd <= ra + sext(imm6).
  - Any other opcode is illegal.
- FSM states: IDLE, OPRD, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid, latch instr and go to OPRD. Otherwise stay.
  - OPRD: load aluA/aluB/aluOp from the decoded fields and register-file reads.
    - ADD: A=R[ra], B=R[rb], op=0.
    - LHI: A=0, B={8'h00,imm8}, op=1.
    - ADDI: A=R[ra], B=sext(imm6), op=0.
    - Illegal: A=B=0, op=0.
    - Go to EXEC.
  - EXEC: capture aluResult into res_q. Go to WB.
  - WB: write res_q to R[rd], except when illegal, or when rd=0 and ZERO_R0=1.
    - Pulse done with done_rd=rd for a legal instruction; pulse illegal instead for an illegal one.
    - Go to IDLE.
- instr_ready is high only in IDLE. Throughput is 1 instruction per 4 cycles.
- Latency: accept at edge T; writeback visible on dbg_data after edge T+3.
- Back-to-back dependency (rd of instruction N = ra of N+1) needs no stall, because OPRD of N+1 is strictly after WB of N.
- Arithmetic is 16-bit modulo; carry is discarded (0xFFFF + 0x0001 = 0x0000).
- aluA, aluB and aluOp hold their values outside OPRD. They are not cleared between instructions.
- instr is ignored outside IDLE. instr_valid held high across busy cycles is not accepted twice; the next acceptance happens only in the next IDLE.
- Reset, including mid-instruction:
  - FSM goes to IDLE; an in-flight instruction is dropped with no writeback and no done.
  - All registers reset to RF_RESET_VAL.
  - aluA=0, aluB=0, aluOp=0, res_q=0, done=0, done_rd=0, illegal=0.
  - instr_ready=1 after reset release.
  - With ZERO_R0=1, r0 reads 0 regardless of RF_RESET_VAL.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=4'h0, OP_LHI=4'h1, OP_ADDI=4'h2.
  - ALU op constants ALU_ADD=1'b0, ALU_LHI=1'b1.
  - FSM state enum.
  - Field bit-position constants.
- One natural sub-module: alu_regfile.
  - 8x16, one write port, three combinational read ports (ra, rb, dbg).
  - Asynchronous reset; ZERO_R0 handling.
- The ALU itself is external and is connected at the top level.

Test Plan:
- Reset then LHI r1,0x12 (instr 16'h1212): aluOp=1, aluB=0x0012 in EXEC; done with done_rd=1; dbg r1=0x1200 after 4 cycles.
- Load r1=0x1200 and r2=0x0034 (ADDI r2,r0,... via LHI/ADDI sequence), then ADD r3,r1,r2 (16'h0650): r3=0x1234; back-to-back dependent ADD r4,r3,r3 gives r4=0x2468.
- ADDI r5,r0,-1 (16'h2A3F): r5=0xFFFF. Then ADDI r5,r5,1 (16'h2B41): r5=0x0000 (wrap, carry dropped).
- Write to r0 (ZERO_R0=1), LHI r0,0xFF: done pulses with done_rd=0, but dbg r0 stays 0x0000.
- Opcode 4'hF: illegal pulses once, done stays 0, no register changes; instr_valid held high for 10 cycles yields exactly 3 acceptances.
- Assert rst_n low during EXEC of an ADD: no done pulse; all registers read 0; instr_ready=1 on the first cycle after reset release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, ALU selects, field positions and issue FSM states
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_LHI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_LHI = 1'b1;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RA_LSB  = 6;
  localparam int RB_LSB  = 3;
  typedef enum logic [1:0] {IDLE, OPRD, EXEC, WB} state_t;
  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file, one write port, three combinational read ports
module alu_regfile #(
  parameter bit          ZERO_R0      = 1'b1,
  parameter logic [15:0] RF_RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ra_addr,
  output logic [15:0] ra_data,
  input  logic [2:0]  rb_addr,
  output logic [15:0] rb_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  logic [15:0] mem [8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 8; i++) mem[i] <= RF_RESET_VAL;
    else if (we && !(ZERO_R0 && waddr == 3'd0))
      mem[waddr] <= wdata;
  // r0 is masked on read so it stays zero whatever the reset value
  assign ra_data  = (ZERO_R0 && ra_addr  == 3'd0) ? '0 : mem[ra_addr];
  assign rb_data  = (ZERO_R0 && rb_addr  == 3'd0) ? '0 : mem[rb_addr];
  assign dbg_data = (ZERO_R0 && dbg_addr == 3'd0) ? '0 : mem[dbg_addr];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one instruction at a time, drives the external ALU
// and writes its result back to the register file
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter bit          ZERO_R0      = 1'b1,
  parameter logic [15:0] RF_RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] aluA,
  output logic [15:0] aluB,
  output logic        aluOp,
  input  logic [15:0] aluResult,
  output logic        done,
  output logic [2:0]  done_rd,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  state_t state, state_n;
  logic [15:0] instr_q, res_q, ra_data, rb_data;
  logic [3:0] opc;
  logic [2:0] rd, ra, rb;
  logic legal;
  assign opc   = instr_q[OPC_LSB +: 4];
  assign rd    = instr_q[RD_LSB +: 3];
  assign ra    = instr_q[RA_LSB +: 3];
  assign rb    = instr_q[RB_LSB +: 3];
  assign legal = opc == OP_ADD || opc == OP_LHI || opc == OP_ADDI;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n     = state;
    instr_ready = state == IDLE;
    done        = state == WB && legal;
    illegal     = state == WB && !legal;
    done_rd     = rd;
    case (state)
      IDLE:    state_n = instr_valid ? OPRD : IDLE;
      OPRD:    state_n = EXEC;
      EXEC:    state_n = WB;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_q <= '0;
      aluA    <= '0;
      aluB    <= '0;
      aluOp   <= ALU_ADD;
      res_q   <= '0;
    end else begin
      if (state == IDLE && instr_valid) instr_q <= instr;
      if (state == OPRD) begin
        aluA  <= (opc == OP_ADD || opc == OP_ADDI) ? ra_data : '0;
        aluB  <= opc == OP_ADD  ? rb_data :
                 opc == OP_LHI  ? {8'h00, instr_q[7:0]} :
                 opc == OP_ADDI ? sext6(instr_q[5:0]) : '0;
        aluOp <= opc == OP_LHI ? ALU_LHI : ALU_ADD;
      end
      if (state == EXEC) res_q <= aluResult;
    end
  alu_regfile #(.ZERO_R0(ZERO_R0), .RF_RESET_VAL(RF_RESET_VAL)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state == WB && legal),
    .waddr    (rd),
    .wdata    (res_q),
    .ra_addr  (ra),
    .ra_data  (ra_data),
    .rb_addr  (rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: vector table plus scoreboard of retire events, with
// hand-written held-valid and mid-instruction reset sequences
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_op;
  logic        done, illegal;
  logic [2:0]  done_rd, dbg_addr;
  logic [15:0] dbg_data;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic        ill;
    logic [15:0] val;
  } vec_t;
  typedef struct {
    logic       ill;
    logic [2:0] rd;
  } exp_t;
  vec_t tv[10];
  exp_t q[$];

  always #5 clk = ~clk;
  assign alu_result = alu_op ? {alu_b[7:0], 8'd0} : alu_a + alu_b;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .aluA        (alu_a),
    .aluB        (alu_b),
    .aluOp       (alu_op),
    .aluResult   (alu_result),
    .done        (done),
    .done_rd     (done_rd),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sweep(input string name, input logic [15:0] exp);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk(name, dbg_data, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (!instr_ready && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) chk("ready_timeout", 16'd0, 16'd1);
    instr = v.instr;
    instr_valid = 1'b1;
    q.push_back('{v.ill, v.instr[11:9]});
    @(posedge clk);
    #1 instr_valid = 1'b0;
    chk("busy_ready", 16'(instr_ready), 16'd0);
    @(posedge clk);
    #1 chk("aluA", alu_a, v.a);
    chk("aluB", alu_b, v.b);
    chk("aluOp", 16'(alu_op), 16'(v.op));
    chk("early_retire", 16'(done | illegal), 16'd0);
    @(posedge clk);
    #1 if (!(done || illegal) || q.size() == 0) chk("retire_timeout", 16'd0, 16'd1);
    else begin
      e = q.pop_front();
      chk("illegal", 16'(illegal), 16'(e.ill));
      chk("done", 16'(done), 16'(!e.ill));
      if (!e.ill) chk("done_rd", 16'(done_rd), 16'(e.rd));
    end
    @(posedge clk);
    #1 dbg_addr = v.instr[11:9];
    #1 chk("rf_rd", dbg_data, v.val);
    chk("ready_after", 16'(instr_ready), 16'd1);
  endtask

  initial begin
    int cnt;
    logic any;
    tv[0] = '{16'h1212, 16'h0000, 16'h0012, 1'b1, 1'b0, 16'h1200};
    tv[1] = '{16'h241A, 16'h0000, 16'h001A, 1'b0, 1'b0, 16'h001A};
    tv[2] = '{16'h0490, 16'h001A, 16'h001A, 1'b0, 1'b0, 16'h0034};
    tv[3] = '{16'h0650, 16'h1200, 16'h0034, 1'b0, 1'b0, 16'h1234};
    tv[4] = '{16'h08D8, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h2468};
    tv[5] = '{16'h2A3F, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF};
    tv[6] = '{16'h2B41, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000};
    tv[7] = '{16'h10FF, 16'h0000, 16'h00FF, 1'b1, 1'b0, 16'h0000};
    tv[8] = '{16'hF200, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h1200};
    tv[9] = '{16'h2D20, 16'h2468, 16'hFFE0, 1'b0, 1'b0, 16'h2448};
    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst_ready", 16'(instr_ready), 16'd1);
    chk("rst_aluA", alu_a, 16'd0);
    chk("rst_aluB", alu_b, 16'd0);
    chk("rst_aluOp", 16'(alu_op), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_done_rd", 16'(done_rd), 16'd0);
    chk("rst_illegal", 16'(illegal), 16'd0);
    sweep("rst_rf", 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_ready", 16'(instr_ready), 16'd1);
    for (int i = 0; i < 10; i++) issue(tv[i]);
    chk("queue_empty", 16'(q.size()), 16'd0);

    // instr_valid held high for ten cycles: accepts at edges 0, 4 and 8 only
    @(negedge clk);
    instr = 16'h2FC1;
    instr_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      if (c == 9) #1 instr_valid = 1'b0;
      @(negedge clk);
      if (done) cnt++;
    end
    chk("held_accepts", 16'(cnt), 16'd3);
    dbg_addr = 3'd7;
    #1 chk("held_r7", dbg_data, 16'h0003);

    // reset while an ADD sits in EXEC
    @(negedge clk);
    instr = 16'h0C50;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_aluA", alu_a, 16'h1200);
    rst_n = 1'b0;
    #1 chk("midrst_ready", 16'(instr_ready), 16'd1);
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_aluA", alu_a, 16'd0);
    chk("midrst_aluB", alu_b, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_rel_ready", 16'(instr_ready), 16'd1);
    sweep("midrst_rf", 16'h0000);
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any = any | done | illegal;
    end
    chk("midrst_no_retire", 16'(any), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
